// File: rtl/breath_sched_pkg.sv
// Shared encodings for the 4-LED breathing scheduler: mode codes, FSM states
// and the channel count.
package breath_pkg;

   localparam int NUM_LED = 4;

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ALL   = 2'b01;
   localparam logic [1:0] MODE_CHASE = 2'b10;
   localparam logic [1:0] MODE_PING  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ALL,
      ST_CHASE,
      ST_PING
   } state_t;

   function automatic state_t mode_to_state(input logic [1:0] m);
      state_t st;
      case (m)
         MODE_ALL:   st = ST_ALL;
         MODE_CHASE: st = ST_CHASE;
         MODE_PING:  st = ST_PING;
         default:    st = ST_IDLE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/breath_sched_if.sv
// Control/status bundle between the board top and the breathing scheduler.
interface breath_sched_if;
   import breath_pkg::*;

   logic               en;
   logic [1:0]         mode;
   logic [NUM_LED-1:0] led;
   logic [1:0]         chan;
   logic               breath_done;

   modport master (output en, mode, input led, chan, breath_done);
   modport slave  (input en, mode, output led, chan, breath_done);
endinterface

// File: rtl/breath_sched_pwm.sv
// Shared breathing-PWM engine: tick prescaler, slot counter and triangular
// duty ramp. breath_done is a combinational strobe on the last frame edge.
module breath_pwm #(
   parameter int TICK_DIV  = 50,
   parameter int PWM_STEPS = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic pwm,
   output logic breath_done
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = $clog2(PWM_STEPS);
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] S_MAX    = SW'(PWM_STEPS - 1);
   localparam logic [SW-1:0] D_ONE    = SW'(1);

   logic [TW-1:0] r_tick;
   logic [SW-1:0] r_s;
   logic [SW-1:0] r_d;
   logic          r_down;
   logic          w_tick_wrap;
   logic          w_frame_end;

   assign w_tick_wrap = (r_tick == TICK_MAX);
   assign w_frame_end = w_tick_wrap && (r_s == S_MAX);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_tick <= '0;
         r_s    <= '0;
         r_d    <= '0;
         r_down <= 1'b0;
      end else begin
         r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
         if (w_tick_wrap)
            r_s <= (r_s == S_MAX) ? '0 : r_s + 1'b1;
         // Duty only moves between frames so each frame has a stable level.
         if (w_frame_end) begin
            if (!r_down) begin
               if (r_d == S_MAX) begin
                  r_down <= 1'b1;
                  r_d    <= r_d - 1'b1;
               end else begin
                  r_d <= r_d + 1'b1;
               end
            end else if (r_d == D_ONE) begin
               r_down <= 1'b0;
               r_d    <= '0;
            end else begin
               r_d <= r_d - 1'b1;
            end
         end
      end
   end

   assign pwm         = (r_s < r_d);
   assign breath_done = w_frame_end && r_down && (r_d == D_ONE);

endmodule

// File: rtl/breath_sched.sv
// Mode FSM for the 4-LED breathing display: picks which LED the shared engine
// lights, steps the channel on breath boundaries, registers all outputs.
module breath_sched
   import breath_pkg::*;
#(
   parameter int TICK_DIV  = 50,
   parameter int PWM_STEPS = 1000
) (
   input  logic           clk,
   input  logic           rst,
   breath_sched_if.slave  bus
);
   state_t             r_state, w_state_next;
   logic [1:0]         r_chan, w_chan_next;
   logic               r_pdir_down, w_pdir_next;
   logic [NUM_LED-1:0] r_led, w_led_next;
   logic               r_done;
   logic               w_pwm;
   logic               w_strobe;
   logic               w_clr;

   assign w_clr = (r_state == ST_IDLE);

   breath_pwm #(
      .TICK_DIV  (TICK_DIV),
      .PWM_STEPS (PWM_STEPS)
   ) u_pwm (
      .clk         (clk),
      .rst         (rst),
      .clr         (w_clr),
      .pwm         (w_pwm),
      .breath_done (w_strobe)
   );

   always_comb begin
      w_state_next = r_state;
      w_chan_next  = r_chan;
      w_pdir_next  = r_pdir_down;
      w_led_next   = '0;

      case (r_state)
         ST_IDLE: begin
            if (bus.en && bus.mode != MODE_OFF) begin
               w_state_next = mode_to_state(bus.mode);
               w_chan_next  = 2'd0;
               w_pdir_next  = 1'b0;
            end
         end
         ST_ALL:  w_led_next = {NUM_LED{w_pwm}};
         default: w_led_next[r_chan] = w_pwm;
      endcase

      // Mode is only sampled here, so a breath is never cut short.
      if (r_state != ST_IDLE && w_strobe) begin
         if (bus.mode == MODE_OFF) begin
            w_state_next = ST_IDLE;
            w_chan_next  = 2'd0;
         end else if (mode_to_state(bus.mode) != r_state) begin
            w_state_next = mode_to_state(bus.mode);
            w_chan_next  = 2'd0;
            w_pdir_next  = 1'b0;
         end else if (r_state == ST_CHASE) begin
            w_chan_next = r_chan + 2'd1;
         end else if (r_state == ST_PING) begin
            if (!r_pdir_down) begin
               if (r_chan == 2'd3) begin
                  w_chan_next = 2'd2;
                  w_pdir_next = 1'b1;
               end else begin
                  w_chan_next = r_chan + 2'd1;
               end
            end else if (r_chan == 2'd0) begin
               w_chan_next = 2'd1;
               w_pdir_next = 1'b0;
            end else begin
               w_chan_next = r_chan - 2'd1;
            end
         end
      end

      if (!bus.en) begin
         w_state_next = ST_IDLE;
         w_chan_next  = 2'd0;
         w_led_next   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_chan      <= 2'd0;
         r_pdir_down <= 1'b0;
         r_led       <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_chan      <= w_chan_next;
         r_pdir_down <= w_pdir_next;
         r_led       <= w_led_next;
         r_done      <= w_strobe;
      end
   end

   assign bus.led         = r_led;
   assign bus.chan        = r_chan;
   assign bus.breath_done = r_done;

endmodule
